// File: rtl/piradspi_pkg.sv
// Shared types for the PiradSPI register-transaction front end:
// engine command layout, MISO response header and controller states.
package piradspi_pkg;

  localparam int CMD_FIFO_WIDTH = 72;
  localparam int SPI_WORD_WIDTH = 32;
  localparam logic [7:0] RESPONSE_MAGIC = 8'hAD;

  // Declared MSB first so the packed layout matches the engine command word.
  typedef struct packed {
    logic [5:0]  rsvd;
    logic        cpol;
    logic        cpha;
    logic [7:0]  id;
    logic [7:0]  device;
    logic [7:0]  sclk_cycles;
    logic [7:0]  wait_start;
    logic [7:0]  csn_to_sclk;
    logic [7:0]  sclk_to_csn;
    logic [15:0] xfer_len;
  } command_t;

  typedef struct packed {
    logic [7:0]  magic;
    logic [7:0]  id;
    logic [15:0] status;
  } response_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_HDR,
    ST_WAIT_DATA,
    ST_RESP
  } state_e;

  function automatic logic header_ok(input response_t hdr, input logic [7:0] id);
    return (hdr.magic == RESPONSE_MAGIC) && (hdr.id == id);
  endfunction

endpackage

// File: rtl/piradspi_frame_pack.sv
// Combinational packing of one register request into the engine command word
// and the single MOSI frame word (rnw, address, data, left-justified).
module piradspi_frame_pack
  import piradspi_pkg::*;
#(
  parameter int ADDR_WIDTH     = 15,
  parameter int REG_DATA_WIDTH = 16,
  parameter int CPOL           = 0,
  parameter int CPHA           = 0,
  parameter int SCLK_CYCLES    = 1,
  parameter int WAIT_START     = 1,
  parameter int CSN_TO_SCLK    = 5,
  parameter int SCLK_TO_CSN    = 5
) (
  input  logic [7:0]                dev_i,
  input  logic [7:0]                id_i,
  input  logic                      rnw_i,
  input  logic [ADDR_WIDTH-1:0]     addr_i,
  input  logic [REG_DATA_WIDTH-1:0] wdata_i,
  output command_t                  cmd_o,
  output logic [SPI_WORD_WIDTH-1:0] mosi_o
);

  localparam int PAD_BITS = SPI_WORD_WIDTH - 1 - ADDR_WIDTH - REG_DATA_WIDTH;

  logic [REG_DATA_WIDTH-1:0] payload;

  // NOTE: the whole struct is defaulted first so no field can infer a latch.
  always_comb begin
    cmd_o             = '0;
    cmd_o.xfer_len    = 16'(SPI_WORD_WIDTH);
    cmd_o.sclk_to_csn = 8'(SCLK_TO_CSN);
    cmd_o.csn_to_sclk = 8'(CSN_TO_SCLK);
    cmd_o.wait_start  = 8'(WAIT_START);
    cmd_o.sclk_cycles = 8'(SCLK_CYCLES);
    cmd_o.device      = dev_i;
    cmd_o.id          = id_i;
    cmd_o.cpha        = 1'(CPHA);
    cmd_o.cpol        = 1'(CPOL);
  end

  assign payload = rnw_i ? '0 : wdata_i;
  assign mosi_o  = SPI_WORD_WIDTH'({rnw_i, addr_i, payload}) << PAD_BITS;

endmodule

// File: rtl/piradspi_reg_xact.sv
// Single-outstanding register transaction controller: issues one command plus
// one MOSI word, then collects the MISO header and data word into a response.
module piradspi_reg_xact
  import piradspi_pkg::*;
#(
  parameter int ADDR_WIDTH     = 15,
  parameter int REG_DATA_WIDTH = 16,
  parameter int CPOL           = 0,
  parameter int CPHA           = 0,
  parameter int SCLK_CYCLES    = 1,
  parameter int WAIT_START     = 1,
  parameter int CSN_TO_SCLK    = 5,
  parameter int SCLK_TO_CSN    = 5,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [7:0]                req_dev,
  input  logic                      req_rnw,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [REG_DATA_WIDTH-1:0] req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [REG_DATA_WIDTH-1:0] rsp_rdata,
  output logic [7:0]                rsp_id,
  output logic                      rsp_err,
  output logic                      cmd_tvalid,
  input  logic                      cmd_tready,
  output logic [CMD_FIFO_WIDTH-1:0] cmd_tdata,
  output logic                      mosi_tvalid,
  input  logic                      mosi_tready,
  output logic [SPI_WORD_WIDTH-1:0] mosi_tdata,
  input  logic                      miso_tvalid,
  output logic                      miso_tready,
  input  logic [SPI_WORD_WIDTH-1:0] miso_tdata,
  output logic [15:0]               dropped_words
);

  localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e                    state_q;
  logic [7:0]                id_cnt_q;
  logic [7:0]                id_q;
  logic [7:0]                dev_q;
  logic                      rnw_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [REG_DATA_WIDTH-1:0] wdata_q;
  logic                      req_ready_q;
  logic                      cmd_tvalid_q;
  logic                      mosi_tvalid_q;
  logic                      miso_tready_q;
  logic                      rsp_valid_q;
  logic [REG_DATA_WIDTH-1:0] rsp_rdata_q;
  logic [7:0]                rsp_id_q;
  logic                      rsp_err_q;
  logic                      err_flag_q;
  logic [15:0]               dropped_q;
  logic [TIMER_WIDTH-1:0]    timer_q;

  logic     req_fire;
  logic     miso_fire;
  logic     cmd_done;
  logic     mosi_done;
  logic     timeout;
  command_t cmd_word;

  assign req_fire  = req_ready_q & req_valid;
  assign miso_fire = miso_tready_q & miso_tvalid;
  // A stream counts as done if it already handshook or handshakes this cycle.
  assign cmd_done  = ~cmd_tvalid_q | cmd_tready;
  assign mosi_done = ~mosi_tvalid_q | mosi_tready;
  assign timeout   = (timer_q == TIMER_LAST);

  piradspi_frame_pack #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .REG_DATA_WIDTH(REG_DATA_WIDTH),
    .CPOL          (CPOL),
    .CPHA          (CPHA),
    .SCLK_CYCLES   (SCLK_CYCLES),
    .WAIT_START    (WAIT_START),
    .CSN_TO_SCLK   (CSN_TO_SCLK),
    .SCLK_TO_CSN   (SCLK_TO_CSN)
  ) u_frame_pack (
    .dev_i  (dev_q),
    .id_i   (id_q),
    .rnw_i  (rnw_q),
    .addr_i (addr_q),
    .wdata_i(wdata_q),
    .cmd_o  (cmd_word),
    .mosi_o (mosi_tdata)
  );

  // NOTE: every register here uses non-blocking assignment so all next values
  // are computed from the pre-edge state regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      id_cnt_q      <= '0;
      id_q          <= '0;
      dev_q         <= '0;
      rnw_q         <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      req_ready_q   <= 1'b0;
      cmd_tvalid_q  <= 1'b0;
      mosi_tvalid_q <= 1'b0;
      miso_tready_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_id_q      <= '0;
      rsp_err_q     <= 1'b0;
      err_flag_q    <= 1'b0;
      dropped_q     <= '0;
      timer_q       <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          req_ready_q   <= 1'b1;
          miso_tready_q <= 1'b1;
          if (miso_fire && dropped_q != 16'hFFFF) dropped_q <= dropped_q + 16'd1;
          if (req_fire) begin
            dev_q         <= req_dev;
            rnw_q         <= req_rnw;
            addr_q        <= req_addr;
            wdata_q       <= req_wdata;
            id_q          <= id_cnt_q;
            id_cnt_q      <= id_cnt_q + 8'd1;
            req_ready_q   <= 1'b0;
            miso_tready_q <= 1'b0;
            cmd_tvalid_q  <= 1'b1;
            mosi_tvalid_q <= 1'b1;
            state_q       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cmd_tready)  cmd_tvalid_q  <= 1'b0;
          if (mosi_tready) mosi_tvalid_q <= 1'b0;
          if (cmd_done && mosi_done) begin
            miso_tready_q <= 1'b1;
            timer_q       <= '0;
            err_flag_q    <= 1'b0;
            state_q       <= ST_WAIT_HDR;
          end
        end
        ST_WAIT_HDR, ST_WAIT_DATA: begin
          timer_q <= timer_q + 1'b1;
          if (miso_fire) begin
            timer_q <= '0;
            if (state_q == ST_WAIT_HDR) begin
              err_flag_q <= ~header_ok(miso_tdata, id_q);
              state_q    <= ST_WAIT_DATA;
            end else begin
              rsp_rdata_q   <= miso_tdata[REG_DATA_WIDTH-1:0];
              rsp_err_q     <= err_flag_q;
              rsp_id_q      <= id_q;
              rsp_valid_q   <= 1'b1;
              miso_tready_q <= 1'b0;
              state_q       <= ST_RESP;
            end
          end else if (timeout) begin
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_id_q      <= id_q;
            rsp_valid_q   <= 1'b1;
            miso_tready_q <= 1'b0;
            state_q       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q   <= 1'b0;
            req_ready_q   <= 1'b1;
            miso_tready_q <= 1'b1;
            state_q       <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign cmd_tvalid    = cmd_tvalid_q;
  assign cmd_tdata     = cmd_word;
  assign mosi_tvalid   = mosi_tvalid_q;
  assign miso_tready   = miso_tready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_err       = rsp_err_q;
  assign dropped_words = dropped_q;

endmodule

// File: tb/tb_piradspi_reg_xact.sv
// Randomized bench for piradspi_reg_xact: a transaction-level model supplies
// expected command/MOSI words and responses; a monitor compares every cycle.
module tb_piradspi_reg_xact;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid, req_ready, req_rnw;
  logic [7:0]  req_dev;
  logic [14:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_rdata;
  logic [7:0]  rsp_id;
  logic        cmd_tvalid, cmd_tready;
  logic [71:0] cmd_tdata;
  logic        mosi_tvalid, mosi_tready;
  logic [31:0] mosi_tdata;
  logic        miso_tvalid, miso_tready;
  logic [31:0] miso_tdata;
  logic [15:0] dropped_words;

  int total = 0;
  int bad   = 0;

  // Model state
  logic [71:0] exp_cmd;
  logic [31:0] exp_mosi;
  logic [15:0] exp_rdata;
  logic [7:0]  exp_rid;
  logic        exp_err;
  logic [7:0]  id_cnt;
  logic [15:0] exp_dropped;

  // Observations of the most recent transaction
  logic [71:0] last_cmd;
  logic [31:0] last_mosi;
  logic [15:0] last_rdata;
  logic [7:0]  last_id;
  logic        last_err;
  int          last_wait;

  always #5 clk = ~clk;

  piradspi_reg_xact #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_dev(req_dev), .req_rnw(req_rnw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_id(rsp_id),
    .rsp_err(rsp_err),
    .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready), .cmd_tdata(cmd_tdata),
    .mosi_tvalid(mosi_tvalid), .mosi_tready(mosi_tready), .mosi_tdata(mosi_tdata),
    .miso_tvalid(miso_tvalid), .miso_tready(miso_tready), .miso_tdata(miso_tdata),
    .dropped_words(dropped_words)
  );

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [71:0] model_cmd(input logic [7:0] dev, input logic [7:0] id);
    logic [71:0] w;
    w = 72'd32;                                   // xfer_len
    w = w + (72'd5 << 16) + (72'd5 << 24);        // sclk_to_csn, csn_to_sclk
    w = w + (72'd1 << 32) + (72'd1 << 40);        // wait_start, sclk_cycles
    w = w + (72'(dev) << 48) + (72'(id) << 56);   // cpha=cpol=0
    return w;
  endfunction

  function automatic logic [31:0] model_mosi(input logic rnw, input logic [14:0] addr,
                                             input logic [15:0] wd);
    return (32'(rnw) << 31) + (32'(addr) << 16) + (rnw ? 32'd0 : 32'(wd));
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (cmd_tvalid)  check("cmd_tdata", cmd_tdata, exp_cmd);
      if (mosi_tvalid) check("mosi_tdata", mosi_tdata, exp_mosi);
      if (rsp_valid) begin
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_id", rsp_id, exp_rid);
        check("rsp_err", rsp_err, exp_err);
        check("req_ready_in_resp", req_ready, 1'b0);
        check("miso_tready_in_resp", miso_tready, 1'b0);
      end
      check("dropped_words", dropped_words, exp_dropped);
    end
  end

  // mode: 0 good header, 1 bad magic, 2 bad id, 3 no MISO words (timeout)
  task automatic xact(input logic [7:0] dev, input logic rnw, input logic [14:0] addr,
                      input logic [15:0] wd, input logic [31:0] data, input int mode,
                      input int cmd_stall, input int rsp_stall, input bit rnd);
    logic [7:0]  id;
    logic [31:0] hdr;
    int n, cmd_hs, mosi_hs;
    n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    check("req_ready_wait", req_ready, 1'b1);
    id       = id_cnt;
    exp_cmd  = model_cmd(dev, id);
    exp_mosi = model_mosi(rnw, addr, wd);
    req_valid = 1'b1; req_dev = dev; req_rnw = rnw; req_addr = addr; req_wdata = wd;
    tick();
    id_cnt    = id_cnt + 8'd1;
    req_valid = 1'b0;
    req_dev = 8'($urandom); req_rnw = 1'($urandom);
    req_addr = 15'($urandom); req_wdata = 16'($urandom);
    check("cmd_tvalid_latency", cmd_tvalid, 1'b1);
    check("mosi_tvalid_latency", mosi_tvalid, 1'b1);
    check("req_ready_busy", req_ready, 1'b0);
    last_cmd  = cmd_tdata;
    last_mosi = mosi_tdata;
    cmd_hs = 0; mosi_hs = 0; n = 0;
    while ((cmd_tvalid || mosi_tvalid) && n < 200) begin
      cmd_tready  = rnd ? 1'($urandom) : (n >= cmd_stall);
      mosi_tready = rnd ? 1'($urandom) : 1'b1;
      if (cmd_tvalid && cmd_tready)   cmd_hs++;
      if (mosi_tvalid && mosi_tready) mosi_hs++;
      tick();
      n++;
    end
    cmd_tready = 1'b0; mosi_tready = 1'b0;
    check("cmd_handshakes", cmd_hs, 1);
    check("mosi_handshakes", mosi_hs, 1);
    check("miso_tready_wait_hdr", miso_tready, 1'b1);
    exp_rid = id;
    if (mode == 3) begin
      exp_rdata = 16'h0; exp_err = 1'b1;
      n = 0;
      while (!rsp_valid && n < 100) begin tick(); n++; end
      last_wait = n;
      check("timeout_cycles", n, TO);
    end else begin
      hdr = {(mode == 1) ? 8'hAC : 8'hAD, (mode == 2) ? (id ^ 8'h5A) : id, 16'($urandom)};
      repeat (rnd ? $urandom_range(0, 8) : 0) tick();
      miso_tvalid = 1'b1; miso_tdata = hdr;
      tick();
      miso_tvalid = 1'b0; miso_tdata = $urandom;
      check("rsp_after_hdr", rsp_valid, 1'b0);
      repeat (rnd ? $urandom_range(0, 8) : 0) tick();
      check("miso_tready_wait_data", miso_tready, 1'b1);
      exp_rdata = data[15:0];
      exp_err   = (hdr[31:24] != 8'hAD) || (hdr[23:16] != id);
      miso_tvalid = 1'b1; miso_tdata = data;
      tick();
      miso_tvalid = 1'b0; miso_tdata = $urandom;
      check("rsp_latency", rsp_valid, 1'b1);
    end
    last_rdata = rsp_rdata; last_id = rsp_id; last_err = rsp_err;
    repeat (rsp_stall) tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_valid_after_accept", rsp_valid, 1'b0);
    check("req_ready_after_resp", req_ready, 1'b1);
  endtask

  task automatic drop_words(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      check("idle_miso_tready", miso_tready, 1'b1);
      miso_tvalid = 1'b1; miso_tdata = $urandom;
      if (miso_tready && exp_dropped != 16'hFFFF) exp_dropped = exp_dropped + 16'd1;
      tick();
      miso_tvalid = 1'b0;
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int mode;
    req_valid = 0; req_dev = 0; req_rnw = 0; req_addr = 0; req_wdata = 0;
    rsp_ready = 0; cmd_tready = 0; mosi_tready = 0; miso_tvalid = 0; miso_tdata = 0;
    id_cnt = 0; exp_dropped = 0;

    // Model pins
    check("model_mosi_write", model_mosi(1'b0, 15'h12, 16'hBEEF), 32'h0012BEEF);
    check("model_mosi_read", model_mosi(1'b1, 15'h7FFF, 16'h1234), 32'hFFFF0000);
    check("model_cmd", model_cmd(8'd3, 8'd0), 72'h00_00_03_01_01_05_05_0020);

    // Reset state
    #12;
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_cmd_tvalid", cmd_tvalid, 1'b0);
    check("rst_mosi_tvalid", mosi_tvalid, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 16'h0);
    check("rst_rsp_id", rsp_id, 8'h0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_dropped", dropped_words, 16'h0);
    tick();
    rstn = 1'b1;
    tick();

    // Write
    xact(8'd3, 1'b0, 15'h12, 16'hBEEF, 32'h0, 0, 0, 0, 1'b0);
    check("wr_cmd_dev", last_cmd[55:48], 8'd3);
    check("wr_cmd_len", last_cmd[15:0], 16'd32);
    check("wr_cmd_id", last_cmd[63:56], 8'd0);
    check("wr_mosi", last_mosi, 32'h0012BEEF);
    check("wr_rsp_err", last_err, 1'b0);
    check("wr_rsp_id", last_id, 8'd0);

    // Read
    xact(8'd3, 1'b1, 15'h7FFF, 16'hFFFF, 32'h00001234, 0, 0, 0, 1'b0);
    check("rd_mosi", last_mosi, 32'hFFFF0000);
    check("rd_rdata", last_rdata, 16'h1234);
    check("rd_id", last_id, 8'd1);
    check("rd_err", last_err, 1'b0);

    // Bad magic, then a clean transaction
    xact(8'd7, 1'b1, 15'h0040, 16'h0, 32'h0000CAFE, 1, 0, 0, 1'b0);
    check("badmagic_err", last_err, 1'b1);
    xact(8'd7, 1'b1, 15'h0041, 16'h0, 32'h00000055, 0, 0, 0, 1'b0);
    check("after_bad_err", last_err, 1'b0);
    check("after_bad_rdata", last_rdata, 16'h0055);

    // Timeout, then two late words dropped in IDLE
    xact(8'd1, 1'b1, 15'h0100, 16'h0, 32'h0, 3, 0, 0, 1'b0);
    check("timeout_wait", last_wait, TO);
    check("timeout_err", last_err, 1'b1);
    check("timeout_rdata", last_rdata, 16'h0);
    drop_words(2);
    check("late_dropped", dropped_words, 16'd2);

    // Backpressure on cmd, held response
    xact(8'd9, 1'b0, 15'h0155, 16'hA5A5, 32'h00003C3C, 0, 5, 10, 1'b0);
    check("bp_id", last_id, 8'd5);
    check("bp_rdata", last_rdata, 16'h3C3C);

    // Reset in the middle of ISSUE
    exp_cmd  = model_cmd(8'h44, id_cnt);
    exp_mosi = model_mosi(1'b0, 15'h0333, 16'h7777);
    req_valid = 1'b1; req_dev = 8'h44; req_rnw = 1'b0; req_addr = 15'h0333; req_wdata = 16'h7777;
    tick();
    req_valid = 1'b0;
    check("pre_rst_cmd_tvalid", cmd_tvalid, 1'b1);
    #2;
    rstn = 1'b0;
    exp_dropped = 16'h0;
    id_cnt = 8'd0;
    #1;
    check("async_cmd_tvalid", cmd_tvalid, 1'b0);
    check("async_mosi_tvalid", mosi_tvalid, 1'b0);
    check("async_req_ready", req_ready, 1'b0);
    check("async_miso_tready", miso_tready, 1'b0);
    check("async_dropped", dropped_words, 16'h0);
    tick();
    tick();
    rstn = 1'b1;

    // 257 random transactions from a fresh id counter
    for (int t = 0; t < 257; t++) begin
      mode = $urandom_range(0, 9);
      mode = (mode <= 6) ? 0 : mode - 6;
      xact(8'($urandom), 1'($urandom), 15'($urandom), 16'($urandom), $urandom, mode,
           0, $urandom_range(0, 3), 1'b1);
      if (t == 0) check("first_id_after_reset", last_id, 8'd0);
      if ($urandom_range(0, 5) == 0) drop_words($urandom_range(1, 2));
    end
    check("id_wrap_257", last_id, 8'd0);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
